// File: rtl/pc_branch_ctrl.sv
// Program-counter and branch sequencer: steps the PC, redirects on jumps and
// flag-qualified branches through a writable target LUT, and tracks run/halt status.
module pc_branch_ctrl #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned LUT_AW     = 5,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              jump_i,
  input  logic              branch_i,
  input  logic [LUT_AW-1:0] lut_idx_i,
  input  logic              flag_i,
  input  logic              flag_we_i,
  input  logic              lut_we_i,
  input  logic [LUT_AW-1:0] lut_waddr_i,
  input  logic [PC_W-1:0]   lut_wdata_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              fetch_en_o,
  output logic              branch_taken_o,
  output logic              flag_o,
  output logic              done_o
);

  localparam int unsigned LUT_N = 1 << LUT_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PC_W-1:0]   r_pc;
  logic              r_flag;
  logic              r_branch_taken;
  logic [PC_W-1:0]   r_lut [LUT_N];

  logic              w_load;
  logic              w_adv;
  logic              w_take;
  logic [PC_W-1:0]   w_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next_state = S_RUN;
      S_RUN:   if (halt_i && !stall_i) w_next_state = S_DONE;
      S_DONE:  if (start_i) w_next_state = S_RUN;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_state != S_RUN) && start_i;
    w_adv      = (r_state == S_RUN) && !stall_i;
    fetch_en_o = w_adv;
    done_o     = (r_state == S_DONE);
    // Branch decision reads the flag stored before this edge; the LUT read
    // likewise sees the entry before any same-cycle write.
    w_take     = !halt_i && (jump_i || (branch_i && r_flag));
    w_target   = r_lut[lut_idx_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= PC_W'(START_ADDR);
      r_flag         <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (w_load) begin
      r_pc           <= PC_W'(START_ADDR);
      r_flag         <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (w_adv) begin
      if (halt_i) begin
        r_branch_taken <= 1'b0;
      end else if (w_take) begin
        r_pc           <= w_target;
        r_branch_taken <= 1'b1;
      end else begin
        r_pc           <= r_pc + PC_W'(1);
        r_branch_taken <= 1'b0;
      end
      if (flag_we_i) r_flag <= flag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LUT_N; i++) r_lut[LUT_AW'(i)] <= '0;
    end else if (lut_we_i) begin
      r_lut[lut_waddr_i] <= lut_wdata_i;
    end
  end

  assign pc_o           = r_pc;
  assign flag_o         = r_flag;
  assign branch_taken_o = r_branch_taken;

endmodule
